if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage plus IF/ID latch, directly upstream of the decode stage.
- Owns the fetch PC and runs a request/acknowledge handshake to instruction memory. Memory latency is variable.
- Presents {pc, inst, valid} to decode. Honours decode stalls and decode-resolved branch redirects, with a single architectural delay slot.
- A one-entry skid buffer absorbs a fetch that completes while decode is stalled.

Parameters:
- PC_RESET, 16'h0000, first fetch address after reset
- NOP_INST, 16'h0800, bubble encoding driven on inst_o when no valid instruction

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
- stall_i  in  1  decode stall request; hold IF/ID latch
- branch_flag_i  in  1  decode taken-branch indication
- branch_addr_i  in  16  branch target from decode
- mem_busy_i  in  1  memory stage owns the shared SRAM; blocks new fetch issue
- inst_req_o  out  1  fetch request
- inst_addr_o  out  16  fetch address; stable while request outstanding
- inst_ack_i  in  1  fetch complete; inst_rdata_i valid this cycle
- inst_rdata_i  in  16  fetched instruction word
- pc_o  out  16  PC of instruction presented to decode
- inst_o  out  16  instruction presented to decode
- inst_valid_o  out  1  pc_o/inst_o hold a real instruction

Behaviour:
- Reset (rst=0 at clk edge), regardless of any outstanding fetch:
  - pc_o=0, inst_o=NOP_INST, inst_valid_o=0
  - fetch_pc=PC_RESET, redirect pending cleared, skid buffer empty, issued flag cleared
  - state=S_IDLE
  - An outstanding request is abandoned; an inst_ack_i arriving in S_IDLE is ignored.
- S_IDLE: inst_req_o=0. Moves unconditionally to S_REQ next cycle.
- S_REQ:
  - inst_req_o = issued | ~mem_busy_i. inst_addr_o=fetch_pc.
  - issued is set on the first cycle the request is driven.
  - Once driven, the request stays high and the address stays frozen until ack, even if mem_busy_i rises.
  - Ack is accepted in the same cycle as the request (zero-wait memory gives one instruction per cycle).
- On ack:
  - issued is cleared.
  - fetch_pc <= target if a redirect is pending, or if branch_flag_i & ~stall_i this cycle. Otherwise fetch_pc <= fetch_pc+1, 16-bit word addressing, wrapping 16'hFFFF -> 16'h0000.
  - The redirect pending flag is cleared.
  - If stall_i=0: the IF/ID latch loads {fetch_pc, inst_rdata_i, 1}; stay in S_REQ.
  - If stall_i=1: the skid buffer loads {fetch_pc, inst_rdata_i}; go to S_HOLD.
- Redirect capture: branch_flag_i & ~stall_i with no ack that cycle records branch_addr_i as pending. It is applied at the next ack.
  - The fetch in flight (or in the skid buffer) when the branch resolves is the delay slot. It is always delivered, never squashed.
- IF/ID latch:
  - stall_i=1: hold all outputs.
  - stall_i=0 with no ack and skid empty: load a bubble {pc_o unchanged, NOP_INST, 0}.
- S_HOLD:
  - inst_req_o=0.
  - When stall_i=0, the latch loads the skid contents with valid=1, the skid is emptied, and state returns to S_REQ.
  - Redirect capture is still active in this state.
- No fetch is issued while the skid is full, so at most one instruction is buffered beyond the latch.
- Latency: ack at cycle t -> inst_o visible at t+1.

Optional Feature:
- Macro: IF_STALL_CNT_EN.
- When defined, adds output ports fetch_wait_cnt_o[15:0] and skid_hold_cnt_o[15:0].
  - fetch_wait_cnt_o counts S_REQ cycles without ack.
  - skid_hold_cnt_o counts S_HOLD cycles.
  - Both are saturating and cleared by reset.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared defines file provides:
  - InstAddrBus/InstBus widths
  - NOP encoding
  - ZeroInstAddr
  - state encodings S_IDLE/S_REQ/S_HOLD
  - RstEnable=1'b0
- One natural sub-module, if_skid_buf: a one-entry {pc, inst} buffer with load/unload/full.
- The FSM, PC logic and IF/ID latch stay in if_fetch.

Test Plan:
- Reset release, zero-wait memory (ack = req), rdata=PC+16'h1000 -> inst_addr_o 0,1,2,...; pc_o/inst_o follow one cycle later; valid=1 each cycle.
- 3-cycle ack latency -> inst_req_o and inst_addr_o held stable 3 cycles; inst_valid_o=0 with NOP_INST 16'h0800 between valid instructions.
- Branch at pc 0x0005 to 0x0040 while fetching 0x0006 -> 0x0006 (delay slot) delivered with valid=1, next inst_addr_o=0x0040.
- stall_i=1 for 4 cycles while ack arrives -> latch held, skid captures, no request during S_HOLD; on release, skid instruction delivered then fetch resumes at next PC.
- mem_busy_i=1 before issue delays request; mem_busy_i rising after issue does not drop request; fetch_pc=0xFFFF wraps to 0x0000.
- rst=0 mid-fetch with ack arriving in the next cycle -> ack ignored; outputs at reset values; first post-reset request at PC_RESET.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the NOP
// encoding, reset polarity, FSM state encoding and the skid entry layout.
package if_fetch_pkg;

    localparam int InstAddrBus = 16;
    localparam int InstBus     = 16;

    localparam logic [InstBus-1:0]     NopInst      = 16'h0800;
    localparam logic [InstAddrBus-1:0] ZeroInstAddr = 16'h0000;

    // Reset is asserted when rst equals this value.
    localparam logic RstEnable = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    // Sequential fetch address; 16-bit word addressing wraps FFFF -> 0000.
    function automatic logic [InstAddrBus-1:0] pc_inc(input logic [InstAddrBus-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic                   inst_req_o;
    logic [InstAddrBus-1:0] inst_addr_o;
    logic                   inst_ack_i;
    logic [InstBus-1:0]     inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_ack_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_ack_i,
        output inst_rdata_i
    );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} buffer that catches a fetch completing while decode
// is stalled. Load wins over unload; only the full flag is reset.
module if_skid_buf
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         unload_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic         full_o
);

    logic         full_q;
    fetch_entry_t data_q;

    // Occupancy flag: set on load, cleared on unload or reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q <= 1'b1;
        end else if (unload_i) begin
            full_q <= 1'b0;
        end
    end

    // Payload register; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage with IF/ID latch. Owns the fetch PC, drives the
// request/ack handshake to instruction memory, honours decode stalls and
// branch redirects (single delay slot), and parks one completed fetch in a
// skid buffer while decode is stalled.
// Optional build macro IF_STALL_CNT_EN adds saturating fetch-wait and
// skid-hold cycle counters as extra outputs.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] PC_RESET = ZeroInstAddr,
    parameter logic [InstBus-1:0]     NOP_INST = NopInst
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [InstAddrBus-1:0] branch_addr_i,
    input  logic                   mem_busy_i,
    if_fetch_if.master             mem,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
`ifdef IF_STALL_CNT_EN
    output logic [15:0]            fetch_wait_cnt_o,
    output logic [15:0]            skid_hold_cnt_o,
`endif
    output logic                   inst_valid_o
);

    fetch_state_e           state_q, state_d;
    logic                   issued_q, issued_d;
    logic [InstAddrBus-1:0] fetch_pc_q, fetch_pc_d;
    logic                   redir_pend_q, redir_pend_d;
    logic [InstAddrBus-1:0] redir_addr_q, redir_addr_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstBus-1:0]     inst_q, inst_d;
    logic                   valid_q, valid_d;

    logic         req;
    logic         ack_acc;
    logic         branch_take;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_full;
    fetch_entry_t skid_in;
    fetch_entry_t skid_out;

    assign branch_take = branch_flag_i & ~stall_i;
    assign skid_in     = '{pc: fetch_pc_q, inst: mem.inst_rdata_i};

    if_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .data_i   (skid_in),
        .data_o   (skid_out),
        .full_o   (skid_full)
    );

    // FSM next state and handshake: request, ack acceptance, skid control.
    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        req         = 1'b0;
        ack_acc     = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // Once issued the request is held even if memory becomes busy.
                req = issued_q | ~mem_busy_i;
                if (req) begin
                    issued_d = 1'b1;
                    if (mem.inst_ack_i) begin
                        ack_acc   = 1'b1;
                        issued_d  = 1'b0;
                        skid_load = stall_i;
                        state_d   = stall_i ? S_HOLD : S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i && skid_full) begin
                    skid_unload = 1'b1;
                    state_d     = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Fetch PC, pending redirect and IF/ID latch next-state.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        redir_pend_d = redir_pend_q;
        redir_addr_d = redir_addr_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        valid_d      = valid_q;

        // The fetch completing at or after a branch is its delay slot; the
        // redirect only steers the address of the fetch after it.
        if (ack_acc) begin
            if (redir_pend_q) begin
                fetch_pc_d = redir_addr_q;
            end else if (branch_take) begin
                fetch_pc_d = branch_addr_i;
            end else begin
                fetch_pc_d = pc_inc(fetch_pc_q);
            end
            redir_pend_d = 1'b0;
        end else if (branch_take) begin
            redir_pend_d = 1'b1;
            redir_addr_d = branch_addr_i;
        end

        if (!stall_i) begin
            if (ack_acc) begin
                pc_d    = fetch_pc_q;
                inst_d  = mem.inst_rdata_i;
                valid_d = 1'b1;
            end else if (skid_unload) begin
                pc_d    = skid_out.pc;
                inst_d  = skid_out.inst;
                valid_d = 1'b1;
            end else begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end
        end
    end

    // State, fetch PC and IF/ID latch registers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q      <= S_IDLE;
            issued_q     <= 1'b0;
            fetch_pc_q   <= PC_RESET;
            redir_pend_q <= 1'b0;
            redir_addr_q <= ZeroInstAddr;
            pc_q         <= ZeroInstAddr;
            inst_q       <= NOP_INST;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            fetch_pc_q   <= fetch_pc_d;
            redir_pend_q <= redir_pend_d;
            redir_addr_q <= redir_addr_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            valid_q      <= valid_d;
        end
    end

`ifdef IF_STALL_CNT_EN
    logic [15:0] wait_cnt_q;
    logic [15:0] hold_cnt_q;

    // Saturating counts of unacknowledged request-state cycles and skid holds.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wait_cnt_q <= 16'd0;
            hold_cnt_q <= 16'd0;
        end else begin
            if (state_q == S_REQ && !ack_acc && wait_cnt_q != 16'hFFFF) begin
                wait_cnt_q <= wait_cnt_q + 16'd1;
            end
            if (state_q == S_HOLD && hold_cnt_q != 16'hFFFF) begin
                hold_cnt_q <= hold_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_wait_cnt_o = wait_cnt_q;
    assign skid_hold_cnt_o  = hold_cnt_q;
`endif

    assign mem.inst_req_o  = req;
    assign mem.inst_addr_o = fetch_pc_q;
    assign pc_o            = pc_q;
    assign inst_o          = inst_q;
    assign inst_valid_o    = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch. The driver plays decode and a
// variable-latency instruction memory, predicts the fetch address stream
// from the branch/delay-slot rules and queues each accepted fetch; a
// separate monitor pops and compares whenever the IF/ID latch loads.
module tb_if_fetch;

    localparam logic [15:0] PC_RST = 16'h0000;
    localparam logic [15:0] NOP    = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [15:0] br_addr = 16'h0000;
    logic        busy = 1'b0;
    logic [15:0] pc_o;
    logic [15:0] inst_o;
    logic        valid_o;
`ifdef IF_STALL_CNT_EN
    logic [15:0] wait_cnt;
    logic [15:0] hold_cnt;
`endif

    if_fetch_if mem_if ();

    if_fetch #(.PC_RESET(PC_RST), .NOP_INST(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .branch_flag_i (br),
        .branch_addr_i (br_addr),
        .mem_busy_i    (busy),
        .mem           (mem_if.master),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
`ifdef IF_STALL_CNT_EN
        .fetch_wait_cnt_o (wait_cnt),
        .skid_hold_cnt_o  (hold_cnt),
`endif
        .inst_valid_o  (valid_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [15:0] exp_addr = PC_RST;
    logic        pend_v = 1'b0;
    logic [15:0] pend_addr = 16'h0000;
    int          wait_left = -1;
    logic [15:0] held_addr = 16'h0000;
    int          acks = 0;
    int          run = 0;
    logic        post_reset = 1'b0;

    // Stimulus knobs
    int          p_stall = 0, p_busy = 0, p_br = 0;
    int          min_lat = 0, max_lat = 0;
    logic        trig_en = 1'b0;
    logic [15:0] trig_pc = 16'h0000, trig_tgt = 16'h0000;

    // Driver -> monitor record of the cycle just clocked
    logic        drv_rst = 1'b0;
    logic        drv_stall = 1'b0;
    logic        drv_acc = 1'b0;
    logic [15:0] drv_addr = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pick_target();
        case ($urandom_range(3))
            0:       return 16'hFFFF;
            1:       return 16'hFFFE;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock of decode + memory stimulus and model update.
    task automatic step(input logic r_n, input logic force_ack);
        logic s, b, bz, req, acc, ack_now;
        logic [15:0] ba, addr, rd;
        @(negedge clk);
        s  = ($urandom_range(99) < p_stall);
        bz = ($urandom_range(99) < p_busy);
        b  = 1'b0;
        ba = pick_target();
        if (!pend_v) begin
            if (trig_en && valid_o && pc_o == trig_pc) begin
                b = 1'b1; s = 1'b0; ba = trig_tgt; trig_en = 1'b0;
            end else if ($urandom_range(99) < p_br) begin
                b = 1'b1;
            end
        end
        rst = r_n; stall = s; br = b; br_addr = ba; busy = bz;
        mem_if.inst_ack_i   = 1'b0;
        mem_if.inst_rdata_i = 16'($urandom);
        #1;
        req  = mem_if.inst_req_o;
        addr = mem_if.inst_addr_o;
        acc  = 1'b0;
        if (!r_n) begin
            exp_q.delete();
            exp_addr = PC_RST; pend_v = 1'b0; wait_left = -1; run = 0;
            post_reset = 1'b1;
        end else begin
            if (post_reset) chk("idle_no_req", {31'b0, req}, 32'd0);
            post_reset = 1'b0;
            if (wait_left >= 0) begin
                chk("req_held", {31'b0, req}, 32'd1);
                chk("addr_frozen", {16'b0, addr}, {16'b0, held_addr});
            end else if (bz) begin
                chk("busy_blocks_issue", {31'b0, req}, 32'd0);
            end
            if (exp_q.size() != 0) chk("skid_full_no_req", {31'b0, req}, 32'd0);
            if (!bz && run >= 2 && exp_q.size() == 0) chk("issue_progress", {31'b0, req}, 32'd1);
            if (req) chk("fetch_addr", {16'b0, addr}, {16'b0, exp_addr});
            if (req && wait_left < 0) begin
                wait_left = $urandom_range(max_lat, min_lat);
                held_addr = addr;
            end
            ack_now = force_ack || (req && wait_left == 0);
            if (ack_now) begin
                rd = exp_addr + 16'h1000;
                mem_if.inst_ack_i   = 1'b1;
                mem_if.inst_rdata_i = rd;
                acc = req;
            end
            if (acc) begin
                exp_q.push_back({exp_addr, rd});
                acks++;
                if (pend_v)      exp_addr = pend_addr;
                else if (b && !s) exp_addr = ba;
                else             exp_addr = exp_addr + 16'd1;
                pend_v = 1'b0;
                wait_left = -1;
            end else begin
                if (req && wait_left > 0) wait_left--;
                if (b && !s) begin pend_v = 1'b1; pend_addr = ba; end
            end
            if (!s && !bz && !req) run++; else run = 0;
        end
        drv_rst = r_n; drv_stall = s; drv_acc = acc; drv_addr = addr;
    endtask

    // Monitor: compare the IF/ID latch after every rising edge.
    logic [15:0] snap_pc = 16'h0000, snap_inst = 16'h0000;
    logic        snap_v = 1'b0;
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!drv_rst) begin
                chk("rst_pc", {16'b0, pc_o}, 32'd0);
                chk("rst_inst", {16'b0, inst_o}, {16'b0, NOP});
                chk("rst_valid", {31'b0, valid_o}, 32'd0);
            end else if (drv_stall) begin
                chk("stall_hold_pc", {16'b0, pc_o}, {16'b0, snap_pc});
                chk("stall_hold_inst", {16'b0, inst_o}, {16'b0, snap_inst});
                chk("stall_hold_valid", {31'b0, valid_o}, {31'b0, snap_v});
            end else begin
                if (drv_acc) chk("ack_to_valid", {31'b0, valid_o}, 32'd1);
                if (valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", {31'b0, valid_o}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pc", {16'b0, pc_o}, {16'b0, e[31:16]});
                        chk("out_inst", {16'b0, inst_o}, {16'b0, e[15:0]});
                        $display("xfer pc=%h inst=%h", pc_o, inst_o);
                    end
                end else begin
                    chk("bubble_inst", {16'b0, inst_o}, {16'b0, NOP});
                    chk("bubble_pc", {16'b0, pc_o}, {16'b0, snap_pc});
                    chk("no_undelivered", exp_q.size(), 32'd0);
                end
            end
            snap_pc = pc_o; snap_inst = inst_o; snap_v = valid_o;
        end
    end

    initial begin
        mem_if.inst_ack_i   = 1'b0;
        mem_if.inst_rdata_i = 16'h0000;
        // Reset, then zero-wait memory
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        // Fixed 3-cycle request-to-ack
        min_lat = 2; max_lat = 2;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        // Branch at pc 5 to 0x40 with zero-wait memory
        min_lat = 0; max_lat = 0;
        step(1'b0, 1'b0);
        trig_en = 1'b1; trig_pc = 16'h0005; trig_tgt = 16'h0040;
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0);
        // Stall for 4 cycles while an ack arrives
        p_stall = 100;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        p_stall = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        // Busy before issue, busy rising after issue
        min_lat = 3; max_lat = 3;
        p_busy = 100;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        p_busy = 0; step(1'b1, 1'b0);
        p_busy = 100;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        p_busy = 0;
        // Wrap: branch to FFFE and run across 0000
        min_lat = 0; max_lat = 0;
        trig_en = 1'b1; trig_pc = pc_o + 16'd1; trig_tgt = 16'hFFFE;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        // Reset mid-fetch with an ack in the following idle cycle
        min_lat = 3; max_lat = 3;
        for (int i = 0; i < 10 && wait_left <= 0; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        // Randomized traffic
        min_lat = 0; max_lat = 3;
        for (int i = 0; i < 1500; i++) begin
            p_stall = 25; p_busy = 20; p_br = 10;
            step(($urandom_range(299) != 0), 1'b0);
        end
        p_stall = 0; p_busy = 0; p_br = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        chk("enough_fetches", {31'b0, (acks >= 300)}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
